apu_audio_out: RTL and testbench
================================

# apu_audio_out

Downstream audio back-end for the APU. Consumes the 16-bit unsigned mixer `Sample` produced every CPU-rate `ce` pulse, decimates it by box-car averaging, buffers results in a small FIFO and serializes them as a mono-duplicated I2S stream for the board codec. It decouples the NES CPU-clock sample rate from the codec bit clock and reports FIFO overflow and underflow.

## Interface
Parameters:
- `DECIM_LOG2`, default 4: decimation factor = 2^DECIM_LOG2 input samples per output word.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `BCLK_DIV`, default 4: `clk` cycles per half period of `i2s_bclk`; must be at least 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ce`  in  1  APU sample strobe; `sample_in` is valid when `ce`=1.
- `sample_in`  in  16  unsigned APU mixer sample (APU `Sample` output).
- `enable`  in  1  decimator enable.
- `clr_flags`  in  1  one-cycle pulse; clears the sticky flags.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrck`  out  1  word select; 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a frame started with an empty FIFO while `enable`=1.

## Operation
- Decimator:
  - On `ce`=1 with `enable`=1: `acc += sample_in` and `cnt += 1`.
  - `acc` width is 16+DECIM_LOG2 bits, so it never overflows.
  - When `cnt` reaches 2^DECIM_LOG2-1 and `ce`=1, compute `avg = (acc + sample_in) >> DECIM_LOG2`, then convert it to two's complement: `word = avg ^ 16'h8000`.
  - Push `word` into the FIFO and clear `acc` and `cnt` in the same cycle.
  - `enable`=0 holds `acc` and `cnt` at 0; no pushes occur.
- FIFO:
  - Synchronous, FIFO_DEPTH x 16.
  - A push while full and not popping in the same cycle drops the word, sets `overflow` and leaves the level unchanged.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Push and pop in the same cycle while empty: the pop sees empty and takes the underflow path, the push is written, and the level becomes 1.
- Serializer:
  - A divider counts 0..BCLK_DIV-1; `i2s_bclk` toggles when the divider reaches BCLK_DIV-1.
  - Slot counter `s` (0..31) advances on each `i2s_bclk` falling transition.
  - `i2s_lrck`=1 for s in 15..30; `i2s_lrck`=0 for s=31 and s in 0..14. This gives the standard one-bit I2S delay.
  - `i2s_sdata`: for s in 0..15 it carries `cur_word[15-s]`; for s in 16..31 it carries `cur_word[31-s]`. The same word is sent on both channels.
  - On entry to s=0: if the FIFO is non-empty, pop the head into `cur_word`. Otherwise keep `cur_word`, and set `underflow` only if `enable`=1.
- Flags: set has priority over `clr_flags` in the same cycle.
- States: the decimator is ACCUM only; the serializer runs continuously as the slot counter. There is no idle state.

## Timing
- Reset values: `i2s_bclk`=0, `i2s_lrck`=0, `i2s_sdata`=0, `fifo_level`=0, `overflow`=0, `underflow`=0, `cur_word`=0, `s`=31, divider=0, `acc`=0, `cnt`=0.
- Reset mid-frame: all state returns immediately to the reset values and FIFO contents are discarded.
- Push latency: the FIFO entry is written, and `fifo_level` increments, 1 clk after the `ce` that completes a block.
- All outputs are registered and change only on `clk` rising edges.
- The `i2s_sdata` and `i2s_lrck` update is the same `clk` edge that drives `i2s_bclk` 1→0.
- `i2s_bclk` period = 2*BCLK_DIV clk; frame = 64*BCLK_DIV clk.
- After reset, the first rising `i2s_bclk` comes at clk edge BCLK_DIV. The first falling edge comes at clk edge 2*BCLK_DIV; it enters s=0 and pops.
- `clr_flags` takes effect on the next edge.

## Test plan
- Reset: hold `reset`=0 with random inputs → all outputs 0. After release, `i2s_bclk` first rises 4 clk later (BCLK_DIV=4) and has an 8-clk period.
- Decimation: 16 `ce` pulses with `sample_in`=16'h8000 → word 16'h0000 pushed and `fifo_level`=1. 16 pulses of 16'hFFFF → 16'h7FFF. Samples alternating 16'h0000/16'h0002 → 16'h8001.
- Framing: preload 16'hA5C3 → left slots 0..15 and right slots 16..31 both emit 1010010111000011. `i2s_lrck` rises at s=15 and falls at s=31.
- Overflow: with the serializer starved (BCLK_DIV large), push 9 words → `fifo_level`=8 and `overflow`=1, and the 9th word is never emitted. `clr_flags` → `overflow`=0. `clr_flags` coincident with another drop → stays 1.
- Underflow: empty FIFO at s=0 with `enable`=1 → previous `cur_word` is repeated and `underflow`=1. With `enable`=0 → repeated, but `underflow` stays 0.
- Full push+pop: FIFO full and a push coincides with entry to s=0 → `fifo_level` stays 8 and `overflow`=0.

Source files
------------

// File: rtl/apu_audio_out.sv
// APU audio back-end: box-car decimator, small sample FIFO and a mono-duplicated
// I2S serializer, all in the single system clock domain.
module apu_audio_out #(
  parameter int DECIM_LOG2 = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ce,
  input  logic [15:0]                   sample_in,
  input  logic                          enable,
  input  logic                          clr_flags,
  output logic                          i2s_bclk,
  output logic                          i2s_lrck,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow,
  output logic [4:0]                    dbg_slot
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = 16 + DECIM_LOG2;
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_DIV - 1);
  localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  // Decimator state
  logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  push;
  logic [15:0]           push_word;

  // FIFO state
  logic [15:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          fifo_empty, fifo_full, pop, push_ok, drop;

  // Serializer state: the slot counter is the only sequencing state
  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
  logic [4:0]       slot_q, slot_d;
  logic [15:0]      cur_q, cur_d;
  logic             bclk_tick, bclk_fall, frame_start;
  logic [3:0]       bit_idx;

  logic ovf_q, ovf_d, udf_q, udf_d;

  // Block average is taken from the sum including the completing sample.
  always_comb begin
    acc_sum   = acc_q + ACC_W'(sample_in);
    push_word = acc_sum[ACC_W-1:DECIM_LOG2] ^ 16'h8000;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (ce) begin
      if (cnt_q == '1) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    bclk_tick   = (div_q == DIV_MAX);
    bclk_fall   = bclk_tick && bclk_q;
    frame_start = bclk_fall && (slot_q == 5'd31);
    div_d       = bclk_tick ? '0 : div_q + 1'b1;
    bclk_d      = bclk_tick ? ~bclk_q : bclk_q;
    slot_d      = bclk_fall ? slot_q + 5'd1 : slot_q;
  end

  // A pop on an empty FIFO is never taken, so an empty push+pop still writes.
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    pop        = frame_start && !fifo_empty;
    push_ok    = push && (!fifo_full || pop);
    drop       = push && !push_ok;
    wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    level_d    = level_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    cur_d      = pop ? mem_q[rd_q] : cur_q;
  end

  // Both channel halves index the word with the low four slot bits inverted.
  always_comb begin
    bit_idx = ~slot_d[3:0];
    lrck_d  = lrck_q;
    sdata_d = sdata_q;
    if (bclk_fall) begin
      lrck_d  = (slot_d >= 5'd15) && (slot_d <= 5'd30);
      sdata_d = cur_d[bit_idx];
    end
  end

  always_comb begin
    ovf_d = drop || (ovf_q && !clr_flags);
    udf_d = (frame_start && fifo_empty && enable) || (udf_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdata_q <= 1'b0;
      slot_q  <= 5'd31;
      cur_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      sdata_q <= sdata_d;
      slot_q  <= slot_d;
      cur_q   <= cur_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage needs no reset: pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign dbg_slot   = slot_q;

endmodule

// File: tb/tb_apu_audio_out.sv
// Directed bench for apu_audio_out: decimation vectors decoded from the I2S
// stream, framing, underflow/overflow flags and FIFO corner cases.
module tb_apu_audio_out;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [15:0] sample_in;
  logic        enable;
  logic        clr_flags;
  logic        i2s_bclk, i2s_lrck, i2s_sdata;
  logic [3:0]  fifo_level;
  logic        overflow, underflow;
  logic [4:0]  dbg_slot;

  apu_audio_out #(.DECIM_LOG2(4), .FIFO_DEPTH(8), .BCLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .ce(ce), .sample_in(sample_in),
    .enable(enable), .clr_flags(clr_flags),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow),
    .dbg_slot(dbg_slot)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          bad;
  } frame_t;
  frame_t frm_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_word;
  } dec_vec_t;

  // I2S receiver model: slot count starts at 31, first falling bclk enters slot 0
  int          slot_m = 31;
  logic        bclk_prev = 1'b0;
  int          fs_cnt = 0;
  int          since_fs = 0;
  logic [15:0] left_sr = '0, right_sr = '0;
  int          lrck_bad = 0;

  always @(posedge clk) begin
    frame_t f;
    logic   exp_lr;
    #1;
    if (!reset) begin
      slot_m    = 31;
      bclk_prev = 1'b0;
      lrck_bad  = 0;
    end else begin
      since_fs++;
      if (i2s_bclk && !bclk_prev) begin
        exp_lr = (slot_m >= 15) && (slot_m <= 30);
        if (i2s_lrck !== exp_lr) lrck_bad++;
        if (slot_m <= 15) left_sr = {left_sr[14:0], i2s_sdata};
        else              right_sr = {right_sr[14:0], i2s_sdata};
        if (slot_m == 31) begin
          f.l = left_sr;
          f.r = right_sr;
          f.bad = lrck_bad;
          frm_q.push_back(f);
          lrck_bad = 0;
        end
      end
      if (!i2s_bclk && bclk_prev) begin
        slot_m = (slot_m + 1) % 32;
        if (slot_m == 0) begin
          fs_cnt++;
          since_fs = 0;
        end
      end
      bclk_prev = i2s_bclk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_fs(input string tag);
    int start;
    int n;
    start = fs_cnt;
    n = 0;
    while (fs_cnt == start && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (fs_cnt == start) begin
      n_total++;
      $display("FAIL timeout_%s: no frame start within %0d clk", tag, n);
    end
  endtask

  task automatic check_frame(input string tag);
    frame_t      f;
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    if (frm_q.size() == 0) begin
      n_total++;
      $display("FAIL %s_frame: got no frame expected word %0h", tag, e);
    end else begin
      f = frm_q.pop_front();
      check({tag, "_left"}, 32'(f.l), 32'(e));
      check({tag, "_right"}, 32'(f.r), 32'(e));
      check({tag, "_lrck"}, 32'(f.bad), 32'd0);
    end
  endtask

  task automatic push_block(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) begin
      ce = 1'b1;
      sample_in = i[0] ? b : a;
      @(negedge clk);
    end
    ce = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_bclk"}, 32'(i2s_bclk), 32'd0);
    check({tag, "_lrck"}, 32'(i2s_lrck), 32'd0);
    check({tag, "_sdata"}, 32'(i2s_sdata), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_udf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    dec_vec_t    vecs[8];
    logic [15:0] s;
    int          n;

    vecs[0] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h7FFF};
    vecs[2] = '{16'h0000, 16'h0002, 16'h8001};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'h0003, 16'h0000, 16'h8001};
    vecs[5] = '{16'h4000, 16'hC000, 16'h0000};
    vecs[6] = '{16'h25C3, 16'h25C3, 16'hA5C3};
    vecs[7] = '{16'h0000, 16'h0000, 16'h8000};

    reset = 1'b0; ce = 1'b0; sample_in = '0; enable = 1'b0; clr_flags = 1'b0;

    // reset held with random inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ce        = 1'($urandom_range(0, 1));
      sample_in = 16'($urandom_range(0, 65535));
      enable    = 1'($urandom_range(0, 1));
      clr_flags = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ce = 1'b0; enable = 1'b1; clr_flags = 1'b0;
    check_outs_zero("rst");
    reset = 1'b1;

    // bclk: first rise at edge 4, period 8
    for (int k = 1; k <= 12; k++) begin
      logic e;
      @(negedge clk);
      e = ((k / 4) % 2) != 0;
      check($sformatf("bclk_edge%0d", k), 32'(i2s_bclk), 32'(e));
    end

    // decimation vectors, each decoded from the frame after its pop
    wait_fs("dec_start");
    for (int v = 0; v < 8; v++) begin
      push_block(vecs[v].a, vecs[v].b);
      check($sformatf("dec%0d_level", v), 32'(fifo_level), 32'd1);
      exp_q.push_back(vecs[v].exp_word);
      wait_fs("dec_pop");
      frm_q.delete();
      wait_fs("dec_frame");
      check_frame($sformatf("dec%0d", v));
    end

    // underflow with enable=1: word repeats, flag sets
    pulse_clr();
    check("udf_clr", 32'(underflow), 32'd0);
    wait_fs("udf_a");
    check("udf_set", 32'(underflow), 32'd1);
    frm_q.delete();
    exp_q.push_back(16'h8000);
    wait_fs("udf_b");
    check_frame("udf_repeat");

    // underflow with enable=0: word repeats, flag stays clear, no pushes
    enable = 1'b0;
    pulse_clr();
    check("udf_clr2", 32'(underflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      ce = 1'b1;
      sample_in = 16'hFFFF;
      @(negedge clk);
    end
    ce = 1'b0;
    check("dis_no_push", 32'(fifo_level), 32'd0);
    wait_fs("dis_a");
    check("dis_udf", 32'(underflow), 32'd0);
    frm_q.delete();
    exp_q.push_back(16'h8000);
    wait_fs("dis_b");
    check_frame("dis_repeat");
    check("dis_udf2", 32'(underflow), 32'd0);

    // re-enable: accumulator starts clean
    enable = 1'b1;
    push_block(16'h0004, 16'h0004);
    check("reen_level", 32'(fifo_level), 32'd1);
    exp_q.push_back(16'h8004);
    wait_fs("reen_pop");
    frm_q.delete();
    wait_fs("reen_frame");
    check_frame("reen");

    // overflow: nine blocks inside one frame, ninth dropped
    for (int k = 1; k <= 9; k++) begin
      s = 16'(k * 16'h1111);
      push_block(s, s);
      if (k <= 8) exp_q.push_back(s ^ 16'h8000);
      if (k == 8) begin
        check("ovf_level8", 32'(fifo_level), 32'd8);
        check("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    check("ovf_level9", 32'(fifo_level), 32'd8);
    check("ovf_set", 32'(overflow), 32'd1);
    pulse_clr();
    check("ovf_clr", 32'(overflow), 32'd0);

    // drop coincident with clr_flags: set wins
    for (int i = 0; i < 16; i++) begin
      ce = 1'b1;
      sample_in = 16'hAAAA;
      clr_flags = (i == 15);
      @(negedge clk);
    end
    ce = 1'b0;
    clr_flags = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_level10", 32'(fifo_level), 32'd8);
    pulse_clr();
    check("ovf_clr2", 32'(overflow), 32'd0);

    // full push coinciding with the slot-0 pop
    n = 0;
    while (since_fs != 240 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (since_fs != 240) begin
      n_total++;
      $display("FAIL timeout_align: since_fs %0d expected 240", since_fs);
    end
    push_block(16'hBBBB, 16'hBBBB);
    exp_q.push_back(16'h3BBB);
    check("full_pp_level", 32'(fifo_level), 32'd8);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_popped", 32'(since_fs), 32'd0);

    // drain: w1..w8, BBBB word, then a repeat (dropped words never appear)
    frm_q.delete();
    exp_q.push_back(16'h3BBB);
    for (int i = 0; i < 10; i++) wait_fs("drain");
    check("drain_frames", 32'(frm_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) check_frame($sformatf("drain%0d", i));
    check("drain_level", 32'(fifo_level), 32'd0);

    // asynchronous reset mid-frame with data pending
    push_block(16'h1234, 16'h1234);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outs_zero("midrst");
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
